tcp_tx_sched: RTL and testbench

TCP_TX_SCHED -- requirements
Module: tcp_tx_sched

---
 rtl/tcp_tx_sched.sv | 156 +++++++++++++++
 tb/tb_tcp_tx_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : tcp_tx_sched
// Brief  : Round-robin TCP flow scheduler, one grant outstanding at a time.
// Rev    : 1.0
// ============================================================================
module tcp_tx_sched #(
    parameter int FLOWID_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sched_en,
    input  logic                app_sched_act_val,
    input  logic [FLOWID_W-1:0] app_sched_act_flowid,
    output logic                sched_app_act_rdy,
    output logic                sched_tx_req_val,
    output logic [FLOWID_W-1:0] sched_tx_req_flowid,
    input  logic                tx_sched_req_rdy,
    input  logic                sched_tx_update_val,
    input  logic [FLOWID_W-1:0] sched_tx_update_flowid,
    input  logic                sched_tx_update_requeue,
    output logic                sched_tx_update_rdy,
    output logic                sched_err,
    output logic [31:0]         stat_grant_cnt
);

    localparam int NUM_FLOWS = 2 ** FLOWID_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_WAIT_UPD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NUM_FLOWS-1:0]  r_pending;
    logic [FLOWID_W-1:0]   r_rr_ptr;
    logic [FLOWID_W-1:0]   r_grant_flowid;
    logic                  r_req_val;
    logic                  r_act_rdy;
    logic                  r_err;
    logic [31:0]           r_grant_cnt;

    logic                  w_grant_start;
    logic                  w_req_acc;
    logic                  w_upd_acc;
    logic                  w_any;
    logic [FLOWID_W-1:0]   w_sel;
    logic [FLOWID_W-1:0]   w_idx;
    logic [NUM_FLOWS-1:0]  w_set;
    logic [NUM_FLOWS-1:0]  w_clr;

    // First pending flow at or after the pointer, wrapping through the top.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            w_idx = r_rr_ptr + FLOWID_W'(i);
            if (!w_any && r_pending[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant_start = 1'b0;
        w_req_acc     = 1'b0;
        w_upd_acc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sched_en && w_any) begin
                    w_grant_start = 1'b1;
                    w_next_state  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (tx_sched_req_rdy) begin
                    w_req_acc    = 1'b1;
                    w_next_state = ST_WAIT_UPD;
                end
            end
            ST_WAIT_UPD: begin
                if (sched_tx_update_val) begin
                    w_upd_acc    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Sets are applied after clears so a same-cycle activation keeps the bit.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_grant_start) begin
            w_clr = NUM_FLOWS'(1) << w_sel;
        end
        if (app_sched_act_val && r_act_rdy) begin
            w_set = w_set | (NUM_FLOWS'(1) << app_sched_act_flowid);
        end
        if (w_upd_acc && sched_tx_update_requeue) begin
            w_set = w_set | (NUM_FLOWS'(1) << r_grant_flowid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_grant_flowid <= '0;
            r_req_val      <= 1'b0;
            r_act_rdy      <= 1'b0;
            r_err          <= 1'b0;
            r_grant_cnt    <= 32'd0;
        end else begin
            r_act_rdy <= 1'b1;
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_req_val <= (w_next_state == ST_GRANT);
            if (w_grant_start) begin
                r_grant_flowid <= w_sel;
            end
            if (w_req_acc) begin
                r_grant_cnt <= r_grant_cnt + 32'd1;
            end
            // A mismatched report still retires the grant actually issued.
            if (w_upd_acc) begin
                r_rr_ptr <= r_grant_flowid + FLOWID_W'(1);
                if (sched_tx_update_flowid != r_grant_flowid) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign sched_app_act_rdy   = r_act_rdy;
    assign sched_tx_req_val    = r_req_val;
    assign sched_tx_req_flowid = r_grant_flowid;
    assign sched_tx_update_rdy = (r_state == ST_WAIT_UPD);
    assign sched_err           = r_err;
    assign stat_grant_cnt      = r_grant_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tcp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_tcp_tx_sched
// Brief  : Directed scoreboard bench for the round-robin TX scheduler.
// Rev    : 1.0
// ============================================================================
module tb_tcp_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sched_en;
    logic        act_val;
    logic [2:0]  act_id;
    logic        act_rdy;
    logic        req_val;
    logic [2:0]  req_id;
    logic        tx_rdy;
    logic        upd_val;
    logic [2:0]  upd_id;
    logic        upd_rq;
    logic        upd_rdy;
    logic        err;
    logic [31:0] cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [2:0]  exp_q[$];
    logic [2:0]  m_exp;

    always #5 clk = ~clk;

    tcp_tx_sched #(.FLOWID_W(3)) u_dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .sched_en               (sched_en),
        .app_sched_act_val      (act_val),
        .app_sched_act_flowid   (act_id),
        .sched_app_act_rdy      (act_rdy),
        .sched_tx_req_val       (req_val),
        .sched_tx_req_flowid    (req_id),
        .tx_sched_req_rdy       (tx_rdy),
        .sched_tx_update_val    (upd_val),
        .sched_tx_update_flowid (upd_id),
        .sched_tx_update_requeue(upd_rq),
        .sched_tx_update_rdy    (upd_rdy),
        .sched_err              (err),
        .stat_grant_cnt         (cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every accepted grant is matched against the next expected flow ID.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && req_val === 1'b1 && tx_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_grant: got flow %0d expected none", req_id);
            end else begin
                m_exp = exp_q.pop_front();
                check("grant_flowid", {29'd0, req_id}, {29'd0, m_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic activate(input logic [2:0] id);
        act_val = 1'b1;
        act_id  = id;
        tick();
        act_val = 1'b0;
    endtask

    task automatic accept_grant();
        int k = 0;
        while (req_val !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        if (req_val !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: got req_val %0b expected 1", req_val);
        end else begin
            tx_rdy = 1'b1;
            tick();
            tx_rdy = 1'b0;
        end
    endtask

    task automatic do_update(input logic [2:0] id, input logic rq,
                             input logic act, input logic [2:0] aid);
        int k = 0;
        while (upd_rdy !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        if (upd_rdy !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL update_timeout: got upd_rdy %0b expected 1", upd_rdy);
        end else begin
            upd_val = 1'b1;
            upd_id  = id;
            upd_rq  = rq;
            act_val = act;
            act_id  = aid;
            tick();
            upd_val = 1'b0;
            upd_rq  = 1'b0;
            act_val = 1'b0;
        end
    endtask

    task automatic no_grant(input int n, input string nm);
        int c = 0;
        repeat (n) begin
            tick();
            if (req_val !== 1'b0) c++;
        end
        check(nm, c, 0);
    endtask

    logic [2:0] rr_ids [3] = '{3'd1, 3'd3, 3'd6};

    initial begin
        int bp_bad;
        rst_n    = 1'b0;
        sched_en = 1'b1;
        act_val  = 1'b0;
        act_id   = '0;
        tx_rdy   = 1'b0;
        upd_val  = 1'b0;
        upd_id   = '0;
        upd_rq   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_val", req_val, 0);
        check("rst_upd_rdy", upd_rdy, 0);
        check("rst_err", err, 0);
        check("rst_cnt", cnt, 0);
        rst_n = 1'b1;
        tick();
        check("first_cycle_no_grant", req_val, 0);
        check("act_rdy_high", act_rdy, 1);

        // Basic path with latency check while the grant is held off.
        exp_q.push_back(3'd5);
        activate(3'd5);
        tick();
        tick();
        check("latency_val", req_val, 1);
        check("latency_flowid", req_id, 5);
        accept_grant();
        do_update(3'd5, 1'b0, 1'b0, 3'd0);
        check("basic_cnt", cnt, 1);
        no_grant(8, "basic_empty");

        // Pointer ends at 7, then pending {2,7} must go 7 before 2.
        exp_q.push_back(3'd6);
        activate(3'd6);
        accept_grant();
        do_update(3'd6, 1'b0, 1'b0, 3'd0);
        sched_en = 1'b0;
        activate(3'd2);
        activate(3'd7);
        sched_en = 1'b1;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd2);
        accept_grant();
        do_update(3'd7, 1'b0, 1'b0, 3'd0);
        accept_grant();
        do_update(3'd2, 1'b0, 1'b0, 3'd0);
        exp_q.push_back(3'd2);
        activate(3'd2);
        accept_grant();
        do_update(3'd2, 1'b0, 1'b0, 3'd0);
        no_grant(5, "wrap_empty");

        // Asynchronous reset while waiting for an update.
        exp_q.push_back(3'd4);
        activate(3'd4);
        accept_grant();
        check("wait_upd_rdy", upd_rdy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_req_val", req_val, 0);
        check("arst_upd_rdy", upd_rdy, 0);
        check("arst_cnt", cnt, 0);
        check("arst_flowid", req_id, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        no_grant(10, "post_reset_idle");

        // Round robin across flows 1, 3, 6, requeued once.
        sched_en = 1'b0;
        activate(3'd1);
        activate(3'd3);
        activate(3'd6);
        sched_en = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int j = 0; j < 3; j++) exp_q.push_back(rr_ids[j]);
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 3; j++) begin
                accept_grant();
                do_update(rr_ids[j], (r == 0), 1'b0, 3'd0);
            end
        end
        check("rr_cnt", cnt, 6);
        no_grant(6, "rr_empty");

        // Backpressure for 10 cycles with enable dropped mid-grant.
        exp_q.push_back(3'd0);
        activate(3'd0);
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_val !== 1'b1 || req_id !== 3'd0) bp_bad++;
            if (i == 4) sched_en = 1'b0;
        end
        check("bp_stable", bp_bad, 0);
        accept_grant();
        check("bp_wait_upd", upd_rdy, 1);
        do_update(3'd0, 1'b0, 1'b0, 3'd0);
        sched_en = 1'b1;
        check("bp_cnt", cnt, 7);

        // Mismatched update: error is sticky and the pointer follows flow 2.
        exp_q.push_back(3'd2);
        activate(3'd2);
        accept_grant();
        do_update(3'd4, 1'b0, 1'b0, 3'd0);
        check("err_set", err, 1);
        sched_en = 1'b0;
        activate(3'd2);
        activate(3'd3);
        sched_en = 1'b1;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd2);
        accept_grant();
        do_update(3'd3, 1'b0, 1'b0, 3'd0);
        accept_grant();
        do_update(3'd2, 1'b0, 1'b0, 3'd0);

        // Activation colliding with grant, then with requeue of the same flow.
        sched_en = 1'b0;
        activate(3'd5);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd5);
        act_val  = 1'b1;
        act_id   = 3'd5;
        sched_en = 1'b1;
        tick();
        act_val = 1'b0;
        accept_grant();
        do_update(3'd5, 1'b0, 1'b0, 3'd0);
        accept_grant();
        do_update(3'd5, 1'b1, 1'b1, 3'd5);
        accept_grant();
        do_update(3'd5, 1'b0, 1'b0, 3'd0);
        no_grant(10, "collision_empty");

        check("final_cnt", cnt, 13);
        check("err_sticky", err, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
